// File: rtl/usb_in_ep_arbiter_if.sv
// rtl/usb_in_ep_arbiter_if.sv - IN endpoint clients and IN buffer port bundle for the arbiter
interface usb_in_ep_arbiter_if #(
    parameter int NUM_EP   = 4,
    parameter int EP_IDX_W = 2
);
    logic [NUM_EP-1:0]   ep_req;
    logic [NUM_EP-1:0]   ep_grant;
    logic [NUM_EP-1:0]   ep_data_free;
    logic [NUM_EP-1:0]   ep_data_put;
    logic [NUM_EP*8-1:0] ep_data;
    logic [NUM_EP-1:0]   ep_data_done;
    logic [NUM_EP-1:0]   ep_stall;
    logic                buf_data_free;
    logic                buf_data_put;
    logic [7:0]          buf_data;
    logic                buf_data_done;
    logic                buf_stall;
    logic [EP_IDX_W-1:0] active_ep;
    logic                busy;

    // Client and buffer side: drives requests, data and buffer status.
    modport master (
        output ep_req, ep_data_put, ep_data, ep_data_done, ep_stall, buf_data_free,
        input  ep_grant, ep_data_free, buf_data_put, buf_data, buf_data_done, buf_stall,
               active_ep, busy
    );

    // Arbiter side.
    modport slave (
        input  ep_req, ep_data_put, ep_data, ep_data_done, ep_stall, buf_data_free,
        output ep_grant, ep_data_free, buf_data_put, buf_data, buf_data_done, buf_stall,
               active_ep, busy
    );
endinterface

// File: rtl/usb_in_ep_arbiter.sv
// rtl/usb_in_ep_arbiter.sv - round-robin arbiter sharing the IN packet-buffer write port
module usb_in_ep_arbiter #(
    parameter int NUM_EP   = 4,
    parameter int EP_IDX_W = 2
) (
    input logic                clk,
    input logic                reset,
    usb_in_ep_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    state_t              state;
    logic [NUM_EP-1:0]   grant_q;
    logic [EP_IDX_W-1:0] owner_q;
    logic [EP_IDX_W-1:0] rr_ptr;
    logic                busy_q;
    logic                pkt_open;

    logic [EP_IDX_W-1:0] pick;
    logic [NUM_EP-1:0]   pick_oh;
    logic                found;
    logic                own_req;
    logic                own_put;
    logic                own_done;
    logic                own_stall;
    logic [7:0]          own_data;
    logic                release_now;
    logic [EP_IDX_W-1:0] next_ptr;

    // First requester scanning from rr_ptr upward, wrapping at NUM_EP; lowest offset wins.
    always_comb begin
        int idx;
        idx     = 0;
        pick    = '0;
        pick_oh = '0;
        found   = 1'b0;
        for (int k = NUM_EP - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_EP) idx = idx - NUM_EP;
            if (bus.ep_req[idx]) begin
                pick         = EP_IDX_W'(idx);
                pick_oh      = '0;
                pick_oh[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

    assign own_req   = bus.ep_req[owner_q];
    assign own_put   = bus.ep_data_put[owner_q];
    assign own_done  = bus.ep_data_done[owner_q];
    assign own_stall = bus.ep_stall[owner_q];
    assign own_data  = bus.ep_data[{owner_q, 3'b000} +: 8];

    // A dropped request only ends ownership when no packet is in flight.
    assign release_now = own_done | own_stall | (~own_req & ~pkt_open & ~own_put);
    assign next_ptr    = (owner_q == EP_IDX_W'(NUM_EP - 1)) ? '0 : owner_q + 1'b1;

    assign bus.ep_grant      = grant_q;
    assign bus.active_ep     = owner_q;
    assign bus.busy          = busy_q;
    assign bus.ep_data_free  = grant_q & {NUM_EP{bus.buf_data_free}};
    assign bus.buf_data_put  = busy_q & own_put & grant_q[owner_q];
    assign bus.buf_data_done = busy_q & own_done;
    assign bus.buf_stall     = busy_q & own_stall;
    assign bus.buf_data      = busy_q ? own_data : 8'h00;

    // Grant FSM: pick owner, hold until packet end or idle drop, then one gap cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            grant_q  <= '0;
            owner_q  <= '0;
            rr_ptr   <= '0;
            busy_q   <= 1'b0;
            pkt_open <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        grant_q <= pick_oh;
                        owner_q <= pick;
                        busy_q  <= 1'b1;
                        state   <= GRANT;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        grant_q  <= '0;
                        busy_q   <= 1'b0;
                        pkt_open <= 1'b0;
                        rr_ptr   <= next_ptr;
                        state    <= GAP;
                    end else if (own_put) begin
                        pkt_open <= 1'b1;
                    end
                end
                GAP:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_usb_in_ep_arbiter.sv
// tb/tb_usb_in_ep_arbiter.sv - self-checking bench for usb_in_ep_arbiter
module tb_usb_in_ep_arbiter;
    localparam int NUM_EP   = 4;
    localparam int EP_IDX_W = 2;

    typedef struct {
        logic [3:0] req;
        logic [3:0] grant;
        int         idx;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    usb_in_ep_arbiter_if #(.NUM_EP(NUM_EP), .EP_IDX_W(EP_IDX_W)) bus ();

    usb_in_ep_arbiter #(.NUM_EP(NUM_EP), .EP_IDX_W(EP_IDX_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    vec_t        vecs[8];
    logic [10:0] exp_q[$];
    int          checks = 0;
    int          fails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic monitor();
        logic [10:0] act;
        act = {bus.buf_data_put, bus.buf_data_done, bus.buf_stall,
               bus.buf_data_put ? bus.buf_data : 8'h00};
        if (bus.buf_data_put || bus.buf_data_done || bus.buf_stall) begin
            if (exp_q.size() == 0) check("unexpected_buf_event", act, 32'h0);
            else                   check("buf_event", act, exp_q.pop_front());
        end
        if (!bus.busy) check("idle_buf_data", bus.buf_data, 32'h0);
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.ep_req        = '0;
        bus.ep_data_put   = '0;
        bus.ep_data       = '0;
        bus.ep_data_done  = '0;
        bus.ep_stall      = '0;
        bus.buf_data_free = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_grant(output int lat);
        lat = 0;
        while (bus.ep_grant == '0 && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic owner_put(input int i, input logic [7:0] b, input logic done);
        bus.ep_data_put[i]   = 1'b1;
        bus.ep_data[i*8 +: 8] = b;
        bus.ep_data_done[i]  = done;
        exp_q.push_back({1'b1, done, 1'b0, b});
        tick();
        bus.ep_data_put[i]  = 1'b0;
        bus.ep_data_done[i] = 1'b0;
    endtask

    task automatic owner_end(input int i, input logic stall);
        if (stall) begin
            bus.ep_stall[i] = 1'b1;
            exp_q.push_back(11'b001_0000_0000);
        end else begin
            bus.ep_data_done[i] = 1'b1;
            exp_q.push_back(11'b010_0000_0000);
        end
        tick();
        bus.ep_stall[i]     = 1'b0;
        bus.ep_data_done[i] = 1'b0;
    endtask

    initial begin
        int lat;
        int gidx[$];
        int gcyc[$];

        vecs[0] = '{4'b0110, 4'b0010, 1};
        vecs[1] = '{4'b0110, 4'b0100, 2};
        vecs[2] = '{4'b0110, 4'b0010, 1};
        vecs[3] = '{4'b1001, 4'b1000, 3};
        vecs[4] = '{4'b1001, 4'b0001, 0};
        vecs[5] = '{4'b1111, 4'b0010, 1};
        vecs[6] = '{4'b0001, 4'b0001, 0};
        vecs[7] = '{4'b1000, 4'b1000, 3};

        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("reset_grant", bus.ep_grant, 32'h0);
        check("reset_busy", bus.busy, 32'h0);
        check("reset_active_ep", bus.active_ep, 32'h0);

        // Round-robin selection table, each owner ends with a zero-length packet.
        for (int i = 0; i < 8; i++) begin
            bus.ep_req = vecs[i].req;
            wait_grant(lat);
            check("vec_latency", lat, 32'd1);
            check("vec_grant", bus.ep_grant, vecs[i].grant);
            check("vec_active_ep", bus.active_ep, vecs[i].idx);
            check("vec_busy", bus.busy, 32'd1);
            check("vec_data_free", bus.ep_data_free, vecs[i].grant);
            owner_end(vecs[i].idx, 1'b0);
            bus.ep_req = '0;
            check("vec_release_grant", bus.ep_grant, 32'h0);
            check("vec_release_busy", bus.busy, 32'h0);
            tick();
        end

        // Owner 1 sends 8 bytes while client 2 strobes junk that must be ignored.
        do_reset();
        bus.ep_req = 4'b0110;
        wait_grant(lat);
        check("pkt_grant", bus.ep_grant, 32'b0010);
        bus.ep_data_put[2]  = 1'b1;
        bus.ep_data[16 +: 8] = 8'hEE;
        for (int b = 0; b < 8; b++) owner_put(1, 8'h10 + 8'(b), 1'b0);
        check("pkt_free_routed", bus.ep_data_free, 32'b0010);
        owner_end(1, 1'b0);
        check("pkt_release_grant", bus.ep_grant, 32'h0);
        tick();
        bus.ep_data_put[2] = 1'b0;
        bus.ep_req[1]      = 1'b0;
        lat = 1;
        while (bus.ep_grant == '0 && lat < 20) begin
            tick();
            lat++;
        end
        check("pkt_turnaround", lat, 32'd2);
        check("pkt_next_grant", bus.ep_grant, 32'b0100);
        owner_end(2, 1'b0);
        bus.ep_req = '0;
        tick();

        // All clients request continuously with single-byte packets.
        do_reset();
        bus.ep_req = 4'b1111;
        for (int c = 0; c < 40 && gidx.size() < 5; c++) begin
            if (bus.ep_grant != '0) begin
                for (int k = 0; k < NUM_EP; k++) begin
                    if (bus.ep_grant[k]) begin
                        gidx.push_back(k);
                        gcyc.push_back(c);
                        bus.ep_data_put[k]    = 1'b1;
                        bus.ep_data_done[k]   = 1'b1;
                        bus.ep_data[k*8 +: 8] = 8'hA0 + 8'(k);
                        exp_q.push_back({3'b110, 8'hA0 + 8'(k)});
                    end
                end
            end
            tick();
            bus.ep_data_put  = '0;
            bus.ep_data_done = '0;
        end
        bus.ep_req = '0;
        check("rotation_count", gidx.size(), 32'd5);
        for (int k = 0; k < gidx.size(); k++) begin
            check("rotation_order", gidx[k], k % NUM_EP);
            if (k > 0) check("rotation_spacing", gcyc[k] - gcyc[k-1], 32'd3);
        end
        tick();
        tick();

        // Owner 2 drops req mid-packet; grant must hold until done.
        do_reset();
        bus.ep_req = 4'b0100;
        wait_grant(lat);
        check("hold_grant_start", bus.ep_grant, 32'b0100);
        bus.ep_req = 4'b1101;
        for (int b = 0; b < 3; b++) owner_put(2, 8'h20 + 8'(b), 1'b0);
        bus.ep_req[2] = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            check("hold_grant", bus.ep_grant, 32'b0100);
        end
        owner_end(2, 1'b0);
        check("hold_release", bus.ep_grant, 32'h0);
        wait_grant(lat);
        check("hold_next_grant", bus.ep_grant, 32'b1000);

        // Stall with no data releases and advances the pointer.
        owner_end(3, 1'b1);
        check("stall_release", bus.ep_grant, 32'h0);
        wait_grant(lat);
        check("stall_next_grant", bus.ep_grant, 32'b0001);

        // Zero-length done releases the same way.
        owner_end(0, 1'b0);
        check("zlp_release_grant", bus.ep_grant, 32'h0);
        check("zlp_release_busy", bus.busy, 32'h0);
        wait_grant(lat);
        check("zlp_next_grant", bus.ep_grant, 32'b1000);

        // Reset while owner 3 is mid-packet.
        owner_put(3, 8'h30, 1'b0);
        owner_put(3, 8'h31, 1'b0);
        reset = 1'b1;
        tick();
        check("midreset_grant", bus.ep_grant, 32'h0);
        check("midreset_busy", bus.busy, 32'h0);
        reset = 1'b0;
        wait_grant(lat);
        check("midreset_next_grant", bus.ep_grant, 32'b0001);
        owner_end(0, 1'b0);
        bus.ep_req = '0;
        tick();
        tick();

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/usb_in_ep_arbiter.md
Name: usb_in_ep_arbiter

Overview:
- Shares the single IN packet-buffer write port of the USB protocol engine between NUM_EP IN endpoint clients: the default control endpoint, CDC ACM notification, CDC TX bulk, and spares.
- Each client uses the existing req/grant/data_free/data_put/data_done/stall convention.
- The arbiter grants one client at a time, round-robin, and muxes that client's data path onto the buffer port.
- Grant is never withdrawn mid-packet.

Parameters:
- NUM_EP, 4, number of IN endpoint clients (2..8).
- EP_IDX_W, 2, width of endpoint index; must satisfy 2**EP_IDX_W >= NUM_EP.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ep_req  in  NUM_EP  per-client request.
- ep_grant  out  NUM_EP  per-client grant, one-hot or zero.
- ep_data_free  out  NUM_EP  buf_data_free routed to the granted client only.
- ep_data_put  in  NUM_EP  per-client byte strobe.
- ep_data  in  NUM_EP*8  per-client byte; client i uses bits [8i+7:8i].
- ep_data_done  in  NUM_EP  per-client end-of-packet strobe.
- ep_stall  in  NUM_EP  per-client stall strobe.
- buf_data_free  in  1  IN buffer has space.
- buf_data_put  out  1  byte write strobe to buffer.
- buf_data  out  8  byte to buffer.
- buf_data_done  out  1  packet complete to buffer.
- buf_stall  out  1  stall to buffer.
- active_ep  out  EP_IDX_W  index of current owner; valid when busy=1.
- busy  out  1  a grant is outstanding.

Behaviour:
- Reset (synchronous, active-high), all registered:
  - ep_grant=0, busy=0, active_ep=0.
  - Round-robin pointer rr_ptr=0, so client 0 has top priority after reset.
  - pkt_open=0, state=IDLE.
- Reset asserted mid-packet drops the grant the next cycle. No done is emitted.
- States:
  - IDLE: if any ep_req is set, select the first requester scanning rr_ptr, rr_ptr+1, ... mod NUM_EP. Register ep_grant one-hot and active_ep, set busy, go to GRANT. Grant appears 1 cycle after req is sampled.
  - GRANT: the owner's signals are muxed combinationally:
    - buf_data_put = ep_data_put[owner] & ep_grant[owner].
    - buf_data = ep_data[owner].
    - buf_data_done = ep_data_done[owner].
    - buf_stall = ep_stall[owner].
    - Non-owners' put/done/stall are ignored. All ep_data_free bits except the owner's read 0.
  - pkt_open:
    - Set on the first owner put.
    - Cleared on owner done or stall.
    - A done with no prior put (zero-length packet) is legal and counts as a packet end.
  - Release from GRANT to GAP occurs on:
    - owner data_done or stall, or
    - owner ep_req low while pkt_open=0.
  - An owner req drop while pkt_open=1 does not release. The grant holds until done or stall.
  - On release, rr_ptr <= (owner+1) mod NUM_EP, and ep_grant clears the next cycle.
  - GAP: one idle cycle with busy=0 and all grants 0, so buffer done/ack bookkeeping settles. Then go to IDLE.
- Done or stall and a new put from the owner in the same cycle: the put is forwarded, then release occurs.
- Minimum turnaround between owners is 3 cycles: release, gap, grant.
- No client is starved. With all NUM_EP clients requesting continuously, each gets one packet per rotation.
- Outputs during IDLE and GAP: buf_data_put=0, buf_data_done=0, buf_stall=0, buf_data=0.
- Requests from absent indices (>= NUM_EP) do not exist, and the pointer wraps at NUM_EP, not 2**EP_IDX_W.

Test Plan:
- Reset, then ep_req=4'b0110 -> ep_grant=4'b0010 one cycle later; active_ep=1; busy=1.
- Owner 1 puts 8 bytes 0x10..0x17 with buf_data_free=1, then done -> buf sees 8 puts with identical bytes plus one done; ep_grant clears; after the gap, ep_grant=4'b0100.
- All four clients request continuously, each sending a single-byte packet -> grant order 0,1,2,3,0 with exactly 3 cycles between successive grants.
- Owner 2 drops req after 3 puts without done -> grant held; done 10 cycles later -> release; no grant to another client in between.
- Owner stalls with no data -> buf_stall pulses 1 cycle; grant released; rr_ptr advances. Separately, a zero-length done releases identically.
- Reset asserted while owner 3 is mid-packet -> ep_grant=0 and busy=0 the next cycle; next requester from index 0 wins first.
